// File: rtl/alu_operand_stage.sv
// Execute-entry operand stage: captures decoded instructions, forms ALU operands
// with writeback forwarding, and buffers them in a main + skid pair for back-pressure.
module alu_operand_stage #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [IDX_W-1:0] in_rs_idx,
  input  logic [IDX_W-1:0] in_rt_idx,
  input  logic [IDX_W-1:0] in_rd_idx,
  input  logic [31:0]      in_rs_val,
  input  logic [31:0]      in_rt_val,
  input  logic [15:0]      in_imm,
  input  logic             in_use_imm,
  input  logic             in_imm_signed,
  input  logic             fwd_valid,
  input  logic [IDX_W-1:0] fwd_idx,
  input  logic [31:0]      fwd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic [2:0]       out_op,
  output logic [IDX_W-1:0] out_rd_idx
);

  typedef struct packed {
    logic             valid;
    logic [2:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rs_idx;
    logic [IDX_W-1:0] rt_idx;
    logic             b_is_reg;
  } entry_t;

  entry_t main_q, skid_q;
  entry_t main_fwd, skid_fwd;
  entry_t cap;
  entry_t main_d, skid_d;

  logic        fwd_live;
  logic        rs_hit, rt_hit;
  logic [31:0] imm_ext;
  logic        accept, drain;

  assign fwd_live = fwd_valid && (fwd_idx != '0);
  assign rs_hit   = fwd_live && (fwd_idx == in_rs_idx);
  assign rt_hit   = fwd_live && (fwd_idx == in_rt_idx);
  assign imm_ext  = in_imm_signed ? {{16{in_imm[15]}}, in_imm} : {16'b0, in_imm};

  assign accept = in_valid && !skid_q.valid;
  assign drain  = main_q.valid && out_ready;

  // Operand formation for the incoming instruction; r0 always reads as zero.
  always_comb begin
    cap          = '0;
    cap.valid    = 1'b1;
    cap.op       = in_op;
    cap.rd_idx   = in_rd_idx;
    cap.rs_idx   = in_rs_idx;
    cap.rt_idx   = in_rt_idx;
    cap.b_is_reg = !in_use_imm;
    if (in_rs_idx == '0) cap.a = '0;
    else if (rs_hit)     cap.a = fwd_data;
    else                 cap.a = in_rs_val;
    if (in_use_imm)           cap.b = imm_ext;
    else if (in_rt_idx == '0) cap.b = '0;
    else if (rt_hit)          cap.b = fwd_data;
    else                      cap.b = in_rt_val;
  end

  // Held entries pick up writeback results so a stall never leaves stale operands.
  always_comb begin
    main_fwd = main_q;
    skid_fwd = skid_q;
    if (main_q.valid && fwd_live) begin
      if (fwd_idx == main_q.rs_idx)                   main_fwd.a = fwd_data;
      if (main_q.b_is_reg && fwd_idx == main_q.rt_idx) main_fwd.b = fwd_data;
    end
    if (skid_q.valid && fwd_live) begin
      if (fwd_idx == skid_q.rs_idx)                   skid_fwd.a = fwd_data;
      if (skid_q.b_is_reg && fwd_idx == skid_q.rt_idx) skid_fwd.b = fwd_data;
    end
  end

  always_comb begin
    main_d = main_fwd;
    skid_d = skid_fwd;
    if (flush) begin
      main_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else if (drain && skid_q.valid) begin
      main_d       = skid_fwd;
      skid_d.valid = 1'b0;
    end else if (accept && (!main_q.valid || drain)) begin
      main_d = cap;
    end else if (accept) begin
      skid_d = cap;
    end else if (drain) begin
      main_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Ready depends only on the skid register, never on out_ready.
  assign in_ready   = !skid_q.valid;
  assign out_valid  = main_q.valid;
  assign out_a      = main_q.a;
  assign out_b      = main_q.b;
  assign out_op     = main_q.op;
  assign out_rd_idx = main_q.rd_idx;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios then random traffic, checked
// against an in-order queue model of the stage with forwarding applied to held entries.
module tb_alu_operand_stage;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_rs_idx, in_rt_idx, in_rd_idx;
  logic [31:0] in_rs_val, in_rt_val;
  logic [15:0] in_imm;
  logic        in_use_imm, in_imm_signed;
  logic        fwd_valid;
  logic [3:0]  fwd_idx;
  logic [31:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_op;
  logic [3:0]  out_rd_idx;

  alu_operand_stage #(.IDX_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_rd_idx(in_rd_idx),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_imm_signed(in_imm_signed),
    .fwd_valid(fwd_valid), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd_idx(out_rd_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    bit          breg;
  } ent_t;

  ent_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_read(input logic [3:0] idx, input logic [31:0] rf_val);
    if (idx == 0) return 32'd0;
    if (fwd_valid && fwd_idx == idx) return fwd_data;
    return rf_val;
  endfunction

  // One clock edge of the reference: flush wins, else held entries see the
  // writeback, the head leaves if consumed, and the input joins if room existed.
  task automatic model_edge();
    ent_t e;
    int   size_before;
    size_before = q.size();
    if (flush) begin
      q.delete();
      return;
    end
    if (fwd_valid && fwd_idx != 0) begin
      foreach (q[i]) begin
        if (q[i].rs == fwd_idx) q[i].a = fwd_data;
        if (q[i].breg && q[i].rt == fwd_idx) q[i].b = fwd_data;
      end
    end
    if (size_before > 0 && out_ready) void'(q.pop_front());
    if (in_valid && size_before < 2) begin
      e.op   = in_op;
      e.rd   = in_rd_idx;
      e.rs   = in_rs_idx;
      e.rt   = in_rt_idx;
      e.breg = !in_use_imm;
      e.a    = reg_read(in_rs_idx, in_rs_val);
      if (in_use_imm)
        e.b = in_imm_signed ? 32'(signed'(in_imm)) : 32'(in_imm);
      else
        e.b = reg_read(in_rt_idx, in_rt_val);
      q.push_back(e);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk({tag, ".out_a"}, out_a, q[0].a);
      chk({tag, ".out_b"}, out_b, q[0].b);
      chk({tag, ".out_op"}, 32'(out_op), 32'(q[0].op));
      chk({tag, ".out_rd"}, 32'(out_rd_idx), 32'(q[0].rd));
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] rs, input logic [3:0] rt,
                       input logic [3:0] rd, input logic [31:0] rsv, input logic [31:0] rtv,
                       input logic [15:0] imm, input logic use_imm, input logic sgn);
    in_valid      = 1'b1;
    in_op         = op;
    in_rs_idx     = rs;
    in_rt_idx     = rt;
    in_rd_idx     = rd;
    in_rs_val     = rsv;
    in_rt_val     = rtv;
    in_imm        = imm;
    in_use_imm    = use_imm;
    in_imm_signed = sgn;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    fwd_valid = 1'b0; fwd_idx = '0; fwd_data = '0;
    drive(3'd0, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0);
    in_valid = 1'b0;

    #3;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_a", out_a, 32'd0);
    chk("rst.out_b", out_b, 32'd0);
    chk("rst.out_op", 32'(out_op), 32'd0);
    chk("rst.out_rd", 32'(out_rd_idx), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // back-to-back ADDs
    drive(3'b000, 4'd1, 4'd2, 4'd4, 32'd5, 32'd7, 16'd0, 1'b0, 1'b0);
    cycle("add1");
    chk("add1.a", out_a, 32'd5);
    chk("add1.b", out_b, 32'd7);
    drive(3'b000, 4'd1, 4'd2, 4'd5, 32'hFFFF_FFFF, 32'd1, 16'd0, 1'b0, 1'b0);
    cycle("add2");
    chk("add2.a", out_a, 32'hFFFF_FFFF);
    chk("add2.b", out_b, 32'd1);
    chk("add2.in_ready", 32'(in_ready), 32'd1);

    // immediate extension
    drive(3'b110, 4'd1, 4'd2, 4'd6, 32'd9, 32'd9, 16'h8001, 1'b1, 1'b1);
    cycle("imm_s");
    chk("imm_s.b", out_b, 32'hFFFF_8001);
    drive(3'b001, 4'd1, 4'd2, 4'd6, 32'd9, 32'd9, 16'h8001, 1'b1, 1'b0);
    cycle("imm_u");
    chk("imm_u.b", out_b, 32'h0000_8001);

    // forwarding at capture, while held, and r0 ignored
    drive(3'b010, 4'd3, 4'd2, 4'd7, 32'd1, 32'd2, 16'd0, 1'b0, 1'b0);
    fwd_valid = 1'b1; fwd_idx = 4'd3; fwd_data = 32'h55;
    cycle("fwd_cap");
    chk("fwd_cap.a", out_a, 32'h55);
    in_valid = 1'b0; out_ready = 1'b0; fwd_data = 32'h66;
    cycle("fwd_held");
    chk("fwd_held.a", out_a, 32'h66);
    fwd_idx = 4'd0; fwd_data = 32'h77;
    cycle("fwd_r0");
    chk("fwd_r0.a", out_a, 32'h66);
    fwd_valid = 1'b0;
    out_ready = 1'b1;
    cycle("drain0");

    // skid fill and in-order drain
    out_ready = 1'b0;
    drive(3'b011, 4'd1, 4'd2, 4'hA, 32'd10, 32'd11, 16'd0, 1'b0, 1'b0);
    cycle("skidA");
    drive(3'b100, 4'd1, 4'd2, 4'hB, 32'd20, 32'd21, 16'd0, 1'b0, 1'b0);
    cycle("skidB");
    chk("skidB.in_ready", 32'(in_ready), 32'd0);
    chk("skidB.rd", 32'(out_rd_idx), 32'hA);
    drive(3'b101, 4'd1, 4'd2, 4'hC, 32'd30, 32'd31, 16'd0, 1'b0, 1'b0);
    cycle("skidC1");
    cycle("skidC2");
    chk("skidC2.rd", 32'(out_rd_idx), 32'hA);
    out_ready = 1'b1;
    cycle("outB");
    chk("outB.rd", 32'(out_rd_idx), 32'hB);
    chk("outB.in_ready", 32'(in_ready), 32'd1);
    cycle("outC");
    chk("outC.rd", 32'(out_rd_idx), 32'hC);
    in_valid = 1'b0;
    cycle("empty");

    // flush with two entries held, then with one entry held
    out_ready = 1'b0;
    drive(3'b000, 4'd1, 4'd2, 4'd1, 32'd1, 32'd2, 16'd0, 1'b0, 1'b0);
    cycle("fl_d");
    drive(3'b000, 4'd1, 4'd2, 4'd2, 32'd3, 32'd4, 16'd0, 1'b0, 1'b0);
    cycle("fl_e");
    drive(3'b000, 4'd1, 4'd2, 4'hF, 32'd5, 32'd6, 16'd0, 1'b0, 1'b0);
    flush = 1'b1;
    cycle("flush2");
    chk("flush2.out_valid", 32'(out_valid), 32'd0);
    chk("flush2.in_ready", 32'(in_ready), 32'd1);
    flush = 1'b0;
    drive(3'b000, 4'd1, 4'd2, 4'd3, 32'd7, 32'd8, 16'd0, 1'b0, 1'b0);
    cycle("fl_g");
    drive(3'b000, 4'd1, 4'd2, 4'hE, 32'd9, 32'd9, 16'd0, 1'b0, 1'b0);
    flush = 1'b1;
    cycle("flush1");
    chk("flush1.out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle("post_flush");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), $urandom, $urandom, 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 25) == 0;
      fwd_valid = 1'($urandom_range(0, 1));
      fwd_idx   = 4'($urandom_range(0, 3));
      fwd_data  = $urandom;
      cycle("rand");
    end
    flush = 1'b0; fwd_valid = 1'b0;

    // asynchronous reset while stalled with both entries valid
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) cycle("pre_rst");
    out_ready = 1'b0;
    drive(3'b111, 4'd1, 4'd2, 4'd8, 32'h1234, 32'h5678, 16'd0, 1'b0, 1'b0);
    cycle("rst_fill1");
    drive(3'b111, 4'd1, 4'd2, 4'd9, 32'h9ABC, 32'hDEF0, 16'd0, 1'b0, 1'b0);
    cycle("rst_fill2");
    chk("rst_fill2.in_ready", 32'(in_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.out_a", out_a, 32'd0);
    chk("arst.out_b", out_b, 32'd0);
    chk("arst.in_ready", 32'(in_ready), 32'd1);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    cycle("post_arst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
